// File: rtl/sdram_arb_pkg.sv
// Shared types, default widths and the round-robin pick for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int DEF_NUM_PORTS   = 3;
    localparam int DEF_ADDR_W      = 25;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_MAX_PENDING = 8;
    localparam int MAX_PORTS       = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PORT_ID_W = id_width(DEF_NUM_PORTS);
    localparam int PTR_W     = id_width(DEF_MAX_PENDING);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    // First set bit of elig at or after ptr, wrapping modulo n.
    function automatic int rr_pick(input logic [MAX_PORTS-1:0] elig, input int ptr, input int n);
        int  pick;
        int  idx;
        bit  found;
        pick  = 0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && elig[idx[$clog2(MAX_PORTS)-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of issuing-port ids for outstanding reads; first-word fall-through.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int WIDTH = PORT_ID_W,
    parameter int DEPTH = DEF_MAX_PENDING
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = id_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin N-port Avalon-MM front end for one SDRAM controller slave,
// routing pipelined read data back to the issuing port through a tag FIFO.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_address,
    input  logic [NUM_PORTS*DATA_W/8-1:0] p_byteenable_n,
    input  logic [NUM_PORTS-1:0]          p_chipselect,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_writedata,
    input  logic [NUM_PORTS-1:0]          p_read_n,
    input  logic [NUM_PORTS-1:0]          p_write_n,
    output logic [DATA_W-1:0]             p_readdata,
    output logic [NUM_PORTS-1:0]          p_readdatavalid,
    output logic [NUM_PORTS-1:0]          p_waitrequest,
    output logic [ADDR_W-1:0]             m_address,
    output logic [DATA_W/8-1:0]           m_byteenable_n,
    output logic                          m_chipselect,
    output logic [DATA_W-1:0]             m_writedata,
    output logic                          m_read_n,
    output logic                          m_write_n,
    input  logic [DATA_W-1:0]             m_readdata,
    input  logic                          m_readdatavalid,
    input  logic                          m_waitrequest,
    output logic                          err_orphan
);

    localparam int BE_W = DATA_W / 8;
    localparam int ID_W = id_width(NUM_PORTS);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [ID_W-1:0]       r_grant;
    logic [ID_W-1:0]       r_rr_ptr;
    logic                  r_is_read;
    logic [ADDR_W-1:0]     r_addr_hold;
    logic [DATA_W-1:0]     r_wdata_hold;
    logic [BE_W-1:0]       r_be_hold;
    logic                  r_err_orphan;

    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_rd;
    logic [NUM_PORTS-1:0]  w_elig;
    logic [MAX_PORTS-1:0]  w_elig_pad;
    logic [ID_W-1:0]       w_pick;
    logic                  w_any_elig;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [ID_W-1:0]       w_fifo_dout;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [BE_W-1:0]       w_sel_be;

    // Read wins when a port asserts both strobes; reads need a free tag slot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign w_rd[gi]   = p_chipselect[gi] & ~p_read_n[gi];
            assign w_req[gi]  = p_chipselect[gi] & (~p_read_n[gi] | ~p_write_n[gi]);
            assign w_elig[gi] = w_req[gi] & (~w_rd[gi] | ~w_fifo_full);
        end
    endgenerate

    assign w_any_elig  = |w_elig;
    assign w_accept    = (r_state == ST_ISSUE) & ~m_waitrequest;
    assign w_push      = w_accept & r_is_read;
    assign w_pop       = m_readdatavalid & ~w_fifo_empty;
    assign w_sel_addr  = p_address[r_grant*ADDR_W +: ADDR_W];
    assign w_sel_wdata = p_writedata[r_grant*DATA_W +: DATA_W];
    assign w_sel_be    = p_byteenable_n[r_grant*BE_W +: BE_W];
    assign err_orphan  = r_err_orphan;
    assign p_readdata  = reset_reset ? '0 : m_readdata;

    always_comb begin
        w_elig_pad                = '0;
        w_elig_pad[NUM_PORTS-1:0] = w_elig;
        w_pick                    = ID_W'(rr_pick(w_elig_pad, int'(r_rr_ptr), NUM_PORTS));
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= ST_ARB;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ARB:   if (w_any_elig) w_state_next = ST_ISSUE;
            ST_ISSUE: if (!m_waitrequest) w_state_next = ST_ARB;
            default:  w_state_next = ST_ARB;
        endcase
    end

    // Strobes follow the command type latched at grant, so a master that drops
    // its request mid-wait still sees the original command complete.
    always_comb begin
        m_chipselect   = 1'b0;
        m_read_n       = 1'b1;
        m_write_n      = 1'b1;
        m_address      = r_addr_hold;
        m_writedata    = r_wdata_hold;
        m_byteenable_n = r_be_hold;
        p_waitrequest  = '1;
        if (r_state == ST_ISSUE) begin
            m_chipselect           = 1'b1;
            m_read_n               = ~r_is_read;
            m_write_n              = r_is_read;
            m_address              = w_sel_addr;
            m_writedata            = w_sel_wdata;
            m_byteenable_n         = w_sel_be;
            p_waitrequest[r_grant] = m_waitrequest;
        end
    end

    always_comb begin
        p_readdatavalid = '0;
        if (w_pop) p_readdatavalid[w_fifo_dout] = 1'b1;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_is_read    <= 1'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_be_hold    <= '1;
            r_err_orphan <= 1'b0;
        end else begin
            if (r_state == ST_ARB && w_any_elig) begin
                r_grant   <= w_pick;
                r_is_read <= w_rd[w_pick];
            end
            if (r_state == ST_ISSUE) begin
                r_addr_hold  <= w_sel_addr;
                r_wdata_hold <= w_sel_wdata;
                r_be_hold    <= w_sel_be;
            end
            if (w_accept) begin
                r_rr_ptr <= (r_grant == ID_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
            end
            if (m_readdatavalid && w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

    sdram_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_grant),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: per-port Avalon masters, a simple controller model and a
// scoreboard of expected commands and read returns.
module tb_sdram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;

    logic              clk_clk = 1'b0;
    logic              reset_reset = 1'b1;
    logic [NP*AW-1:0]  p_address;
    logic [NP*BW-1:0]  p_byteenable_n;
    logic [NP-1:0]     p_chipselect;
    logic [NP*DW-1:0]  p_writedata;
    logic [NP-1:0]     p_read_n;
    logic [NP-1:0]     p_write_n;
    logic [DW-1:0]     p_readdata;
    logic [NP-1:0]     p_readdatavalid;
    logic [NP-1:0]     p_waitrequest;
    logic [AW-1:0]     m_address;
    logic [BW-1:0]     m_byteenable_n;
    logic              m_chipselect;
    logic [DW-1:0]     m_writedata;
    logic              m_read_n;
    logic              m_write_n;
    logic [DW-1:0]     m_readdata;
    logic              m_readdatavalid;
    logic              m_waitrequest;
    logic              err_orphan;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_PENDING (8)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .p_address       (p_address),
        .p_byteenable_n  (p_byteenable_n),
        .p_chipselect    (p_chipselect),
        .p_writedata     (p_writedata),
        .p_read_n        (p_read_n),
        .p_write_n       (p_write_n),
        .p_readdata      (p_readdata),
        .p_readdatavalid (p_readdatavalid),
        .p_waitrequest   (p_waitrequest),
        .m_address       (m_address),
        .m_byteenable_n  (m_byteenable_n),
        .m_chipselect    (m_chipselect),
        .m_writedata     (m_writedata),
        .m_read_n        (m_read_n),
        .m_write_n       (m_write_n),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest),
        .err_orphan      (err_orphan)
    );

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be_n;
    } cmd_t;

    typedef struct {
        logic [NP-1:0] onehot;
        logic [DW-1:0] data;
    } rdv_t;

    typedef struct {
        cmd_t          cmd;
        logic [NP-1:0] exp_rdv;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    cmd_t  exp_cmd_q[$];
    rdv_t  exp_rdv_q[$];
    cmd_t  mq[NP][32];
    int    mq_head[NP];
    int    mq_tail[NP];
    cmd_t  cur[NP];
    logic  [NP-1:0] act;
    logic  [NP-1:0] acc;
    vec_t  vecs[6];

    int    n_pass = 0;
    int    n_total = 0;
    int    wr_low_total = 0;
    int    ret_limit;
    int    ret_count = 0;
    bit    ctrl_wait;
    bit    force_orphan;
    logic [DW-1:0] ret_q[$];

    function automatic cmd_t mk(input int p, input bit wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [BW-1:0] be);
        cmd_t c;
        c.port = p; c.wr = wr; c.addr = a; c.wdata = d; c.be_n = be;
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_total++;
        if (actual === required) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    endtask

    task automatic send(input cmd_t c, input logic [NP-1:0] rdv1h, input logic [DW-1:0] rdata,
                        input bit expect_it);
        mq[c.port][mq_tail[c.port] % 32] = c;
        mq_tail[c.port]++;
        if (expect_it) begin
            rdv_t r;
            r.onehot = rdv1h;
            r.data   = rdata;
            exp_cmd_q.push_back(c);
            if (!c.wr) exp_rdv_q.push_back(r);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_cmd_q.size() != 0 || exp_rdv_q.size() != 0) && n < budget) begin
            @(negedge clk_clk);
            n++;
        end
        check("drain_cmd_left", exp_cmd_q.size(), 0);
        check("drain_rdv_left", exp_rdv_q.size(), 0);
        exp_cmd_q.delete();
        exp_rdv_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_waitrequest"}, p_waitrequest, 3'b111);
        check({tag, "_p_readdatavalid"}, p_readdatavalid, 3'b000);
        check({tag, "_m_chipselect"}, m_chipselect, 1'b0);
        check({tag, "_m_read_n"}, m_read_n, 1'b1);
        check({tag, "_m_write_n"}, m_write_n, 1'b1);
        check({tag, "_m_address"}, m_address, 25'h0);
        check({tag, "_m_writedata"}, m_writedata, 16'h0);
        check({tag, "_m_byteenable_n"}, m_byteenable_n, 2'b11);
        check({tag, "_p_readdata"}, p_readdata, 16'h0);
        check({tag, "_err_orphan"}, err_orphan, 1'b0);
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        exp_cmd_q.delete();
        exp_rdv_q.delete();
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
    endtask

    // Per-port Avalon masters: hold each command until waitrequest is seen low.
    initial begin
        act = '0;
        acc = '0;
        p_chipselect = '0; p_read_n = '1; p_write_n = '1;
        p_address = '0; p_writedata = '0; p_byteenable_n = '1;
        for (int i = 0; i < NP; i++) begin
            mq_head[i] = 0;
            cur[i] = mk(i, 1'b0, '0, '0, '1);
        end
        forever begin
            @(negedge clk_clk);
            for (int i = 0; i < NP; i++) acc[i] = act[i] & ~p_waitrequest[i];
            @(posedge clk_clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (reset_reset) begin
                    act[i] = 1'b0;
                    mq_head[i] = mq_tail[i];
                end else begin
                    if (acc[i]) act[i] = 1'b0;
                    if (!act[i] && mq_head[i] != mq_tail[i]) begin
                        cur[i] = mq[i][mq_head[i] % 32];
                        mq_head[i]++;
                        act[i] = 1'b1;
                    end
                end
                p_chipselect[i]           = act[i];
                p_read_n[i]               = !(act[i] && !cur[i].wr);
                p_write_n[i]              = !(act[i] && cur[i].wr);
                p_address[i*AW +: AW]     = cur[i].addr;
                p_writedata[i*DW +: DW]   = cur[i].wdata;
                p_byteenable_n[i*BW +: BW] = cur[i].be_n;
            end
        end
    end

    // Controller model: read data is the low 16 bits of the read address.
    initial begin
        logic          racc;
        logic [AW-1:0] raddr;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        forever begin
            @(negedge clk_clk);
            racc  = m_chipselect && !m_read_n && !m_waitrequest;
            raddr = m_address;
            @(posedge clk_clk);
            #1;
            m_waitrequest   = ctrl_wait;
            m_readdatavalid = 1'b0;
            m_readdata      = '0;
            if (reset_reset) begin
                ret_q.delete();
            end else begin
                if (racc) ret_q.push_back(raddr[DW-1:0]);
                if (force_orphan) begin
                    m_readdatavalid = 1'b1;
                    m_readdata      = 16'hDEAD;
                end else if (ret_q.size() > 0 && ret_count < ret_limit) begin
                    m_readdatavalid = 1'b1;
                    m_readdata      = ret_q.pop_front();
                    ret_count++;
                end
            end
        end
    end

    // Scoreboard: compare accepted commands and routed read data.
    initial begin
        cmd_t          c;
        rdv_t          r;
        logic [NP-1:0] gnt;
        logic [NP-1:0] exp1h;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset) begin
                if (!m_write_n) wr_low_total++;
                if (m_chipselect && !m_waitrequest) begin
                    gnt = ~p_waitrequest;
                    if (exp_cmd_q.size() == 0) begin
                        check("cmd_unexpected_port", gnt, 3'b000);
                    end else begin
                        c = exp_cmd_q.pop_front();
                        exp1h = NP'(1) << c.port;
                        $display("cmd  port=%0d wr=%0d addr=%07h wdata=%04h be_n=%02b", c.port, c.wr, m_address, m_writedata, m_byteenable_n);
                        check("cmd_port", gnt, exp1h);
                        check("cmd_addr", m_address, c.addr);
                        check("cmd_strobes", {m_read_n, m_write_n}, {c.wr, !c.wr});
                        check("cmd_be_n", m_byteenable_n, c.be_n);
                        if (c.wr) check("cmd_wdata", m_writedata, c.wdata);
                    end
                end
                if (p_readdatavalid != 0 || (m_readdatavalid && exp_rdv_q.size() > 0)) begin
                    if (exp_rdv_q.size() == 0) begin
                        check("rdv_unexpected", p_readdatavalid, 3'b000);
                    end else begin
                        r = exp_rdv_q.pop_front();
                        $display("rdv  onehot=%03b data=%04h", p_readdatavalid, p_readdata);
                        check("rdv_onehot", p_readdatavalid, r.onehot);
                        check("rdv_data", p_readdata, r.data);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        vecs[0] = '{mk(1, 1'b1, 25'h0001234, 16'hBEEF, 2'b00), 3'b000, 16'h0000};
        vecs[1] = '{mk(0, 1'b0, 25'h1FFFFFF, 16'h0000, 2'b00), 3'b001, 16'hFFFF};
        vecs[2] = '{mk(2, 1'b0, 25'h0000000, 16'h0000, 2'b00), 3'b100, 16'h0000};
        vecs[3] = '{mk(0, 1'b1, 25'h1FFFFFF, 16'h0001, 2'b10), 3'b000, 16'h0000};
        vecs[4] = '{mk(1, 1'b0, 25'h0ABCDEF, 16'h0000, 2'b00), 3'b010, 16'hCDEF};
        vecs[5] = '{mk(2, 1'b1, 25'h1555555, 16'hA5A5, 2'b01), 3'b000, 16'h0000};

        for (int i = 0; i < NP; i++) mq_tail[i] = 0;
        ctrl_wait    = 1'b0;
        force_orphan = 1'b0;
        ret_limit    = 1 << 30;

        repeat (2) @(negedge clk_clk);
        check_reset_outputs("in_reset");
        do_reset();
        check_reset_outputs("after_reset");

        // Single commands from the vector table.
        for (int v = 0; v < 6; v++) begin
            w0 = wr_low_total;
            send(vecs[v].cmd, vecs[v].exp_rdv, vecs[v].exp_rdata, 1'b1);
            wait_drain(100);
            repeat (2) @(negedge clk_clk);
            check("vec_write_strobe_cycles", wr_low_total - w0, vecs[v].cmd.wr ? 1 : 0);
        end

        // Simultaneous reads from ports 0 and 2 straight after reset.
        do_reset();
        send(mk(0, 1'b0, 25'h000AAAA, 16'h0, 2'b00), 3'b001, 16'hAAAA, 1'b1);
        send(mk(2, 1'b0, 25'h0005555, 16'h0, 2'b00), 3'b100, 16'h5555, 1'b1);
        wait_drain(100);

        // All ports busy: grants must rotate 0,1,2 three times.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NP; i++) begin
                logic [AW-1:0] a;
                a = 25'h100 + AW'(i * 16 + k);
                send(mk(i, ((i + k) % 2) == 1, a, 16'h7000 + DW'(i * 16 + k), 2'b00),
                     NP'(1) << i, a[DW-1:0], 1'b1);
            end
        end
        wait_drain(200);

        // Controller stalls a port-1 read for 5 cycles while port 0 waits.
        do_reset();
        ctrl_wait = 1'b1;
        @(negedge clk_clk);
        send(mk(1, 1'b0, 25'h0001111, 16'h0, 2'b00), 3'b010, 16'h1111, 1'b1);
        repeat (2) @(negedge clk_clk);
        send(mk(0, 1'b1, 25'h0002222, 16'h4444, 2'b00), 3'b000, 16'h0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("stall_m_address", m_address, 25'h0001111);
            check("stall_m_read_n", m_read_n, 1'b0);
            check("stall_p0_waitrequest", p_waitrequest[0], 1'b1);
            @(negedge clk_clk);
        end
        ctrl_wait = 1'b0;
        wait_drain(100);

        // Tag FIFO full: a 9th read stalls, a write still goes through.
        do_reset();
        ret_limit = ret_count;
        for (int k = 0; k < 8; k++)
            send(mk(0, 1'b0, 25'h300 + AW'(k), 16'h0, 2'b00), 3'b001, 16'h0300 + DW'(k), 1'b1);
        n = 0;
        while (exp_cmd_q.size() != 0 && n < 100) begin @(negedge clk_clk); n++; end
        check("fill_reads_issued", exp_cmd_q.size(), 0);
        send(mk(2, 1'b1, 25'h0000400, 16'h1357, 2'b00), 3'b000, 16'h0, 1'b1);
        send(mk(1, 1'b0, 25'h0000309, 16'h0, 2'b00), 3'b010, 16'h0309, 1'b1);
        n = 0;
        while (exp_cmd_q.size() > 1 && n < 50) begin @(negedge clk_clk); n++; end
        repeat (6) @(negedge clk_clk);
        check("full_read_stalled", exp_cmd_q.size(), 1);
        check("full_read_p1_wait", p_waitrequest[1], 1'b1);
        ret_limit = ret_count + 1;
        n = 0;
        while (exp_cmd_q.size() != 0 && n < 50) begin @(negedge clk_clk); n++; end
        check("ninth_read_issued", exp_cmd_q.size(), 0);
        ret_limit = 1 << 30;
        wait_drain(100);
        check("no_orphan_in_normal_use", err_orphan, 1'b0);

        // Orphan read data, then reset asserted during an ISSUE stall.
        do_reset();
        force_orphan = 1'b1;
        @(negedge clk_clk);
        check("orphan_no_rdv", p_readdatavalid, 3'b000);
        force_orphan = 1'b0;
        @(negedge clk_clk);
        check("orphan_set", err_orphan, 1'b1);
        repeat (5) @(negedge clk_clk);
        check("orphan_sticky", err_orphan, 1'b1);
        ctrl_wait = 1'b1;
        @(negedge clk_clk);
        send(mk(0, 1'b1, 25'h0000777, 16'h9999, 2'b00), 3'b000, 16'h0, 1'b0);
        n = 0;
        while (!m_chipselect && n < 20) begin @(negedge clk_clk); n++; end
        check("midissue_chipselect", m_chipselect, 1'b1);
        reset_reset = 1'b1;
        #1;
        check_reset_outputs("mid_issue_reset");
        ctrl_wait = 1'b0;
        do_reset();
        send(mk(2, 1'b0, 25'h0000ABC, 16'h0, 2'b00), 3'b100, 16'h0ABC, 1'b1);
        wait_drain(100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Parametrised N-port Avalon-MM front end for the SDRAM controller's Avalon slave. It lets NUM_PORTS masters (video, CPU, DMA) share one SDRAM controller. Requests are granted round-robin and forwarded unchanged. Pipelined read responses go back to the issuing port through an in-order tag FIFO. Defaults match the current controller: 25-bit word address, 16-bit data, active-low byte enables.

Parameters:
NUM_PORTS, 3, number of upstream Avalon slave ports (2..8)
ADDR_W, 25, word address width
DATA_W, 16, data width; byte-enable width BE_W = DATA_W/8
MAX_PENDING, 8, maximum reads in flight; tag FIFO depth (power of 2)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous active-high reset
p_address  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
p_byteenable_n  in  NUM_PORTS*BE_W  per-port active-low byte enables
p_chipselect  in  NUM_PORTS  per-port chipselect
p_writedata  in  NUM_PORTS*DATA_W  per-port write data
p_read_n  in  NUM_PORTS  per-port active-low read
p_write_n  in  NUM_PORTS  per-port active-low write
p_readdata  out  DATA_W  read data, broadcast to all ports
p_readdatavalid  out  NUM_PORTS  one-hot read-data-valid
p_waitrequest  out  NUM_PORTS  per-port waitrequest
m_address  out  ADDR_W  to controller
m_byteenable_n  out  BE_W  to controller
m_chipselect  out  1  to controller
m_writedata  out  DATA_W  to controller
m_read_n  out  1  to controller
m_write_n  out  1  to controller
m_readdata  in  DATA_W  from controller
m_readdatavalid  in  1  from controller
m_waitrequest  in  1  from controller
err_orphan  out  1  sticky: readdatavalid received with no read outstanding

Behaviour:
- Clock and reset: single clock clk_clk. Reset reset_reset is asynchronous and active-high. Reset clears state, grant, rotation pointer, FIFO and err_orphan.
- Outputs during and after reset: p_waitrequest all 1s; p_readdatavalid 0; m_chipselect 0; m_read_n 1; m_write_n 1; m_address, m_writedata, p_readdata 0; m_byteenable_n all 1s.
- Port i requests when p_chipselect[i] & (~p_read_n[i] | ~p_write_n[i]). Read and write asserted together on one port: treat as a read.
- Eligibility: a read request is eligible only if the tag FIFO is not full. A write request is always eligible.
- FSM states:
  - ARB: if any port is eligible, register grant = first eligible port at or after rr_ptr (wrapping mod NUM_PORTS), go to ISSUE. Otherwise stay.
  - ISSUE: m_* driven combinationally from the granted port; m_chipselect = 1. p_waitrequest[grant] = m_waitrequest; all other ports read 1.
- Command acceptance: when ISSUE and m_waitrequest == 0:
  - if a read, push grant onto the tag FIFO;
  - rr_ptr <= grant+1, wrapping to 0 past NUM_PORTS-1;
  - return to ARB.
- Grant hold: while m_waitrequest == 1 the grant is held, even if the port drops its request. A dropped request is an Avalon protocol violation; the command completes unchanged.
- Throughput: one command per 2 cycles. Minimum added request latency is 1 cycle (the ARB cycle).
- Read return: on m_readdatavalid, pop the FIFO head h and assert p_readdatavalid[h] for that same cycle (combinational). p_readdata = m_readdata (combinational pass-through).
- Simultaneous push and pop is legal: occupancy is unchanged. A push while full cannot occur because of the eligibility rule.
- Orphan data: m_readdatavalid with the FIFO empty sets err_orphan, cleared only by reset. The data is dropped and no p_readdatavalid is raised.
- Reset mid-operation: the outstanding command is abandoned and queued tags are discarded. The controller is on the same reset, so no return data is expected afterwards.
- Outside ISSUE: m_* data and address hold their last values; only the chipselect, read and write strobes return to idle.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - localparams for the default widths;
  - clog2-based PORT_ID_W and PTR_W;
  - FSM state enum {ST_ARB, ST_ISSUE};
  - the round-robin pick function.
- Sub-module sdram_tag_fifo: synchronous FIFO, width PORT_ID_W, depth MAX_PENDING. Ports push, pop, din, dout (first-word fall-through), full, empty. Asynchronous active-high reset.

Test Plan:
- Port 1 writes addr 0x0001234 data 0xBEEF, m_waitrequest low → m_write_n low for exactly 1 cycle with those values; p_waitrequest[1] drops that cycle.
- Ports 0 and 2 read simultaneously, controller returns 0xAAAA then 0x5555 → grant order 0 then 2; p_readdatavalid 3'b001 with 0xAAAA, then 3'b100 with 0x5555.
- All 3 ports request continuously, 9 commands → grant sequence 0,1,2,0,1,2,0,1,2.
- m_waitrequest held high 5 cycles during a port-1 read while port 0 requests → m_address stable from port 1; p_waitrequest[0] stays 1; port 0 issues next.
- 8 reads issued with no readdatavalid, then a 9th read and a write requested → read stalls, write issues; after one readdatavalid the 9th read issues.
- m_readdatavalid pulse with no reads pending → err_orphan = 1 and stays 1; reset_reset asserted mid-ISSUE → all outputs return to reset values the same cycle.
